mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit address / 8-bit data memory bus between two masters: m0 (CPU core) and m1 (DMA/video fetch).
- Accepts one access per master through a req/ack handshake, drives the shared bus strobes for a fixed wait-state count, returns read data, and pulses ack.
- Arbitration is round-robin by default; an optional m1-priority mode is bounded by a starvation limit so the CPU always makes progress.

Parameters:
- WAIT_STATES, 1, extra cycles the mem_r/mem_w strobe is held beyond the first (strobe length = WAIT_STATES+1 cycles; legal 0..15).
- MAX_BURST, 8, in priority mode, the maximum number of consecutive m1 grants while m0 is requesting (legal 1..255).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  m0 access request; held with m0_we/m0_addr/m0_wdata stable until m0_ack.
- m0_we  input  1  1 = write, 0 = read.
- m0_addr  input  16  m0 address.
- m0_wdata  input  8  m0 write data.
- m0_rdata  output  8  read data returned to m0.
- m0_ack  output  1  one-cycle completion pulse to m0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as m0 (widths 1, 1, 16, 8, 8, 1) for master m1.
- prio_m1  input  1  1 = m1 fixed priority with starvation limit; 0 = round-robin.
- mem_addr  output  16  shared bus address.
- mem_wdata  output  8  shared bus write data.
- mem_rdata  input  8  shared bus read data, valid on the last strobe cycle.
- mem_r  output  1  read strobe.
- mem_w  output  1  write strobe.
- owner  output  1  index of the master currently or last granted.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-access):
  - state = IDLE; mem_r = mem_w = 0; m0_ack = m1_ack = 0.
  - mem_addr = 0, mem_wdata = 0, m0_rdata = m1_rdata = 0.
  - owner = 1, so m0 wins the first tie; burst counter = 0; wait counter = 0.
  - An interrupted access is abandoned with no ack.
- FSM IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - At a posedge where any req is high, select a master, then:
    - load mem_addr and mem_wdata from that master;
    - set mem_r = ~we and mem_w = we;
    - set owner to the selected master; wait counter = WAIT_STATES;
    - go to ACCESS.
  - With no req high, all outputs hold.
- Selection:
  - Only one req high: grant that master.
  - Both high, prio_m1 = 0: grant ~owner (strict alternation).
  - Both high, prio_m1 = 1: grant m1 unless burst counter == MAX_BURST, in which case grant m0.
- Burst counter:
  - Increments on each m1 grant made while m0_req is high.
  - Clears on any m0 grant, or when m0_req is low at a grant decision.
  - Saturates at MAX_BURST.
- ACCESS:
  - Strobe and bus outputs hold.
  - Wait counter > 0: decrement.
  - Wait counter == 0: at that posedge, capture mem_rdata into the owner's rdata (reads only; rdata is unchanged on writes), deassert mem_r/mem_w, pulse the owner's ack for exactly one cycle, and go to DONE.
- DONE: one cycle; req is ignored; go to IDLE. The master updates or drops its req at the posedge that ends the ack cycle.
- Latency: req sampled at edge E0 -> strobe high E0..E(W+1) -> ack high for cycle E(W+1)..E(W+2) -> next grant no earlier than E(W+3). Peak throughput is one access per WAIT_STATES+3 cycles.
- mem_addr and mem_wdata hold their last values after an access; they do not return to 0.
- The non-owner ack is always 0. Both acks are never high together, and mem_r and mem_w are never high together.
- The granted master's req dropping mid-ACCESS is a protocol violation; the access still completes and ack still pulses.
- A change of prio_m1 takes effect at the next IDLE decision only.

Test Plan:
- Reset, then m0 read of 0x2000 with mem_rdata = 0xA5, WAIT_STATES = 1 -> mem_r high for 2 cycles with mem_addr = 0x2000; m0_rdata = 0xA5 and m0_ack one cycle later; busy falls after DONE.
- m1 write of 0x5A to 0x1F00 -> mem_w high for 2 cycles, mem_wdata = 0x5A, m1_ack pulses, m1_rdata unchanged (0x00).
- Both req held continuously, prio_m1 = 0, 6 accesses -> owner sequence 0,1,0,1,0,1; each ack goes only to the granted master.
- prio_m1 = 1, MAX_BURST = 3, both req held -> grant sequence 1,1,1,0,1,1,1,0; with m0_req low the whole time, m1 is granted every slot and never forced off.
- Assert reset during ACCESS of an m0 read -> mem_r = 0, no m0_ack, state IDLE; after release with m1_req high, m1 is granted first.
- WAIT_STATES = 0, back-to-back m0 reads -> strobe 1 cycle, ack every 3 cycles, mem_r and mem_w never both high.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a shared 16-bit address / 8-bit data memory bus.
// Round-robin by default; optional m1 priority bounded by a starvation limit.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic [7:0]  m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m1_rdata,
    output logic        m1_ack,

    input  logic        prio_m1,

    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_r,
    output logic        mem_w,
    output logic        owner,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: a master raises req with we/addr/wdata and holds them stable
    // until ack; ack is a one-cycle pulse, and req is only sampled in IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [7:0]  burst_cnt;

    logic        any_req;
    logic        sel;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic [7:0]  burst_next;

    assign any_req   = m0_req | m1_req;
    assign sel_we    = sel ? m1_we    : m0_we;
    assign sel_addr  = sel ? m1_addr  : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;
    assign state_dbg = state;

    always_comb begin
        sel = m1_req;
        if (m0_req && m1_req) begin
            if (prio_m1) begin
                sel = (burst_cnt != BURST_MAX);
            end else begin
                sel = ~owner;
            end
        end
    end

    // Counts m1 grants that overtook a waiting m0; saturates at the limit.
    always_comb begin
        burst_next = 8'd0;
        if (sel && m0_req) begin
            burst_next = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= 16'd0;
            mem_wdata <= 8'd0;
            mem_r     <= 1'b0;
            mem_w     <= 1'b0;
            m0_rdata  <= 8'd0;
            m1_rdata  <= 8'd0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            owner     <= 1'b1;
            busy      <= 1'b0;
            wait_cnt  <= 4'd0;
            burst_cnt <= 8'd0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_r     <= ~sel_we;
                        mem_w     <= sel_we;
                        owner     <= sel;
                        busy      <= 1'b1;
                        wait_cnt  <= WAIT_INIT;
                        burst_cnt <= burst_next;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        // mem_rdata is valid on the last strobe cycle only.
                        if (mem_r) begin
                            if (owner) begin
                                m1_rdata <= mem_rdata;
                            end else begin
                                m0_rdata <= mem_rdata;
                            end
                        end
                        mem_r <= 1'b0;
                        mem_w <= 1'b0;
                        if (owner) begin
                            m1_ack <= 1'b1;
                        end else begin
                            m0_ack <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(mem_r && mem_w));
    a_ack_excl:    assert property (@(posedge clk) disable iff (reset) !(m0_ack && m1_ack));
    a_ack_done:    assert property (@(posedge clk) disable iff (reset)
                                    (m0_ack || m1_ack) |-> (state == DONE));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (WAIT_STATES 1/MAX_BURST 3 and
// WAIT_STATES 0), a transaction-age reference model and directed scenarios.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    typedef struct packed {
        int          age;
        logic        owner;
        int          burst;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
    } mdl_t;

    typedef struct packed {
        logic [7:0]  m0_rdata;
        logic        m0_ack;
        logic [7:0]  m1_rdata;
        logic        m1_ack;
        logic [15:0] mem_addr;
        logic [7:0]  mem_wdata;
        logic        mem_r;
        logic        mem_w;
        logic        owner;
        logic        busy;
    } dout_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic started = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        m0_req[2], m0_we[2], m1_req[2], m1_we[2], prio_m1[2];
    logic [15:0] m0_addr[2], m1_addr[2];
    logic [7:0]  m0_wdata[2], m1_wdata[2], mem_rdata[2];

    logic [7:0]  u0_m0_rdata, u0_m1_rdata, u0_mem_wdata, u1_m0_rdata, u1_m1_rdata, u1_mem_wdata;
    logic [15:0] u0_mem_addr, u1_mem_addr;
    logic        u0_m0_ack, u0_m1_ack, u0_mem_r, u0_mem_w, u0_owner, u0_busy;
    logic        u1_m0_ack, u1_m1_ack, u1_mem_r, u1_mem_w, u1_owner, u1_busy;
    logic [1:0]  u0_state, u1_state;
    dout_t       o[2];

    always_comb begin
        o[0] = {u0_m0_rdata, u0_m0_ack, u0_m1_rdata, u0_m1_ack, u0_mem_addr,
                u0_mem_wdata, u0_mem_r, u0_mem_w, u0_owner, u0_busy};
        o[1] = {u1_m0_rdata, u1_m0_ack, u1_m1_rdata, u1_m1_ack, u1_mem_addr,
                u1_mem_wdata, u1_mem_r, u1_mem_w, u1_owner, u1_busy};
    end

    mem_bus_arbiter #(.WAIT_STATES(1), .MAX_BURST(3)) u0 (
        .clk(clk), .reset(rst),
        .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
        .m0_rdata(u0_m0_rdata), .m0_ack(u0_m0_ack),
        .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
        .m1_rdata(u0_m1_rdata), .m1_ack(u0_m1_ack),
        .prio_m1(prio_m1[0]),
        .mem_addr(u0_mem_addr), .mem_wdata(u0_mem_wdata), .mem_rdata(mem_rdata[0]),
        .mem_r(u0_mem_r), .mem_w(u0_mem_w), .owner(u0_owner), .busy(u0_busy),
        .state_dbg(u0_state)
    );

    mem_bus_arbiter #(.WAIT_STATES(0), .MAX_BURST(8)) u1 (
        .clk(clk), .reset(rst),
        .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
        .m0_rdata(u1_m0_rdata), .m0_ack(u1_m0_ack),
        .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
        .m1_rdata(u1_m1_rdata), .m1_ack(u1_m1_ack),
        .prio_m1(prio_m1[1]),
        .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_rdata(mem_rdata[1]),
        .mem_r(u1_mem_r), .mem_w(u1_mem_w), .owner(u1_owner), .busy(u1_busy),
        .state_dbg(u1_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int   n_checks = 0;
    int   n_pass   = 0;
    logic dut_g[$];
    logic mdl_g[$];
    int   ack_cyc[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Each access is tracked by its age in cycles since the grant edge: the
    // strobe covers ages 0..W, ack is age W+1, and the bus is free after that.
    mdl_t md[2];

    function automatic int wof(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n = '0;
        n.age   = -1;
        n.owner = 1'b1;
        return n;
    endfunction

    function automatic mdl_t model_next(input int i, input mdl_t c);
        mdl_t n;
        logic sel;
        int   w;
        int   mb;
        n   = c;
        sel = 1'b0;
        w   = wof(i);
        mb  = (i == 0) ? 3 : 8;
        if (c.age < 0) begin
            if (m0_req[i] || m1_req[i]) begin
                if (m0_req[i] && m1_req[i]) sel = prio_m1[i] ? (c.burst < mb) : !c.owner;
                else sel = m1_req[i];
                if (sel && m0_req[i]) n.burst = (c.burst < mb) ? c.burst + 1 : mb;
                else n.burst = 0;
                n.owner = sel;
                n.age   = 0;
                n.we    = sel ? m1_we[i]    : m0_we[i];
                n.addr  = sel ? m1_addr[i]  : m0_addr[i];
                n.wdata = sel ? m1_wdata[i] : m0_wdata[i];
            end
        end else if (c.age + 1 == w + 1) begin
            n.age = c.age + 1;
            if (!c.we) begin
                if (c.owner) n.rd1 = mem_rdata[i];
                else n.rd0 = mem_rdata[i];
            end
        end else if (c.age + 1 > w + 1) begin
            n.age = -1;
        end else begin
            n.age = c.age + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md[0] <= mdl_reset();
            md[1] <= mdl_reset();
        end else begin
            md[0] <= model_next(0, md[0]);
            md[1] <= model_next(1, md[1]);
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic chk_model(input int i);
        mdl_t m;
        logic strobe;
        logic ackp;
        m      = md[i];
        strobe = (m.age >= 0) && (m.age <= wof(i));
        ackp   = (m.age == wof(i) + 1);
        chk($sformatf("u%0d.mem_r", i),     16'(o[i].mem_r),  16'(strobe && !m.we));
        chk($sformatf("u%0d.mem_w", i),     16'(o[i].mem_w),  16'(strobe && m.we));
        chk($sformatf("u%0d.m0_ack", i),    16'(o[i].m0_ack), 16'(ackp && !m.owner));
        chk($sformatf("u%0d.m1_ack", i),    16'(o[i].m1_ack), 16'(ackp && m.owner));
        chk($sformatf("u%0d.busy", i),      16'(o[i].busy),   16'(m.age >= 0));
        chk($sformatf("u%0d.owner", i),     16'(o[i].owner),  16'(m.owner));
        chk($sformatf("u%0d.mem_addr", i),  o[i].mem_addr,    m.addr);
        chk($sformatf("u%0d.mem_wdata", i), 16'(o[i].mem_wdata), 16'(m.wdata));
        chk($sformatf("u%0d.m0_rdata", i),  16'(o[i].m0_rdata),   16'(m.rd0));
        chk($sformatf("u%0d.m1_rdata", i),  16'(o[i].m1_rdata),   16'(m.rd1));
        chk($sformatf("u%0d.strobe_excl", i), 16'(o[i].mem_r & o[i].mem_w), 16'd0);
        chk($sformatf("u%0d.ack_excl", i),    16'(o[i].m0_ack & o[i].m1_ack), 16'd0);
    endtask

    logic prev_busy0 = 1'b0;
    always @(negedge clk) begin
        if (started) begin
            chk_model(0);
            chk_model(1);
            if (o[0].busy && !prev_busy0) dut_g.push_back(o[0].owner);
            if (md[0].age == 0) mdl_g.push_back(md[0].owner);
            prev_busy0 = o[0].busy;
        end
    end

    // ---------------- master drivers ----------------
    // Queue index = 2*instance + master; head is presented until acked.
    txn_t mq[4][$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[2*i].delete();
                mq[2*i+1].delete();
            end else begin
                if (o[i].m0_ack && mq[2*i].size() != 0) void'(mq[2*i].pop_front());
                if (o[i].m1_ack && mq[2*i+1].size() != 0) void'(mq[2*i+1].pop_front());
            end
            m0_req[i] = (mq[2*i].size() != 0);
            m1_req[i] = (mq[2*i+1].size() != 0);
            m0_we[i] = 1'b0; m0_addr[i] = 16'd0; m0_wdata[i] = 8'd0;
            m1_we[i] = 1'b0; m1_addr[i] = 16'd0; m1_wdata[i] = 8'd0;
            if (m0_req[i]) begin
                m0_we[i] = mq[2*i][0].we; m0_addr[i] = mq[2*i][0].addr; m0_wdata[i] = mq[2*i][0].wdata;
            end
            if (m1_req[i]) begin
                m1_we[i] = mq[2*i+1][0].we; m1_addr[i] = mq[2*i+1][0].addr; m1_wdata[i] = mq[2*i+1][0].wdata;
            end
        end
    end

    task automatic push(input int i, input int m, input logic we, input logic [15:0] a, input logic [7:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        mq[2*i+m].push_back(t);
    endtask

    task automatic run_idle(input int i, input int budget, output int nr, output int nw,
                            output int a0, output int a1);
        int k;
        nr = 0; nw = 0; a0 = 0; a1 = 0;
        ack_cyc.delete();
        @(negedge clk);
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (o[i].mem_r) nr++;
            if (o[i].mem_w) nw++;
            if (o[i].m0_ack) a0++;
            if (o[i].m1_ack) a1++;
            if (o[i].m0_ack || o[i].m1_ack) ack_cyc.push_back(cyc);
            if (!o[i].busy && mq[2*i].size() == 0 && mq[2*i+1].size() == 0) break;
        end
        chk($sformatf("u%0d.run_timeout", i), 16'(k < budget), 16'd1);
    endtask

    task automatic chk_seq(input string nm, input int n, input logic [7:0] exp);
        chk({nm, ".dut_len"}, 16'(dut_g.size()), 16'(n));
        chk({nm, ".mdl_len"}, 16'(mdl_g.size()), 16'(n));
        for (int k = 0; k < n; k++) begin
            if (k < dut_g.size()) chk($sformatf("%s.dut[%0d]", nm, k), 16'(dut_g[k]), 16'(exp[k]));
            if (k < mdl_g.size()) chk($sformatf("%s.mdl[%0d]", nm, k), 16'(mdl_g[k]), 16'(exp[k]));
        end
    endtask

    task automatic clear_log();
        dut_g.delete();
        mdl_g.delete();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int nr, nw, a0, a1, k;
        prio_m1[0] = 1'b0; prio_m1[1] = 1'b0;
        mem_rdata[0] = 8'h00; mem_rdata[1] = 8'h00;
        #1 rst = 1'b1;
        #1 started = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("reset.owner", 16'(o[0].owner), 16'd1);
        chk("reset.busy", 16'(o[0].busy), 16'd0);
        chk("reset.mem_addr", o[0].mem_addr, 16'h0000);
        chk("reset.state_u0", 16'(u0_state), 16'd0);
        chk("reset.state_u1", 16'(u1_state), 16'd0);

        // m0 read, 2-cycle strobe
        clear_log();
        mem_rdata[0] = 8'hA5;
        push(0, 0, 1'b0, 16'h2000, 8'h00);
        run_idle(0, 30, nr, nw, a0, a1);
        chk("rd0.strobes", 16'(nr), 16'd2);
        chk("rd0.m0_acks", 16'(a0), 16'd1);
        chk("rd0.m1_acks", 16'(a1), 16'd0);
        chk("rd0.m0_rdata", 16'(o[0].m0_rdata), 16'h00A5);
        chk("rd0.mem_addr", o[0].mem_addr, 16'h2000);
        chk_seq("rd0.grants", 1, 8'h00);

        // m1 write
        clear_log();
        push(0, 1, 1'b1, 16'h1F00, 8'h5A);
        run_idle(0, 30, nr, nw, a0, a1);
        chk("wr1.strobes", 16'(nw), 16'd2);
        chk("wr1.rd_strobes", 16'(nr), 16'd0);
        chk("wr1.m1_acks", 16'(a1), 16'd1);
        chk("wr1.m0_acks", 16'(a0), 16'd0);
        chk("wr1.mem_wdata", 16'(o[0].mem_wdata), 16'h005A);
        chk("wr1.m1_rdata", 16'(o[0].m1_rdata), 16'h0000);
        chk_seq("wr1.grants", 1, 8'h01);

        // round-robin, both held
        clear_log();
        mem_rdata[0] = 8'h3C;
        for (int j = 0; j < 3; j++) begin
            push(0, 0, 1'b0, 16'h2100 + 16'(j), 8'h00);
            push(0, 1, 1'b1, 16'h3000 + 16'(j), 8'h10 + 8'(j));
        end
        run_idle(0, 60, nr, nw, a0, a1);
        chk("rr.m0_acks", 16'(a0), 16'd3);
        chk("rr.m1_acks", 16'(a1), 16'd3);
        chk("rr.m0_rdata", 16'(o[0].m0_rdata), 16'h003C);
        chk_seq("rr.grants", 6, 8'h2A);

        // m1 priority with starvation limit 3
        clear_log();
        prio_m1[0] = 1'b1;
        mem_rdata[0] = 8'h5E;
        for (int j = 0; j < 2; j++) push(0, 0, 1'b1, 16'h4000 + 16'(j), 8'hC0 + 8'(j));
        for (int j = 0; j < 6; j++) push(0, 1, 1'b0, 16'h5000 + 16'(j), 8'h00);
        run_idle(0, 80, nr, nw, a0, a1);
        chk("prio.m0_acks", 16'(a0), 16'd2);
        chk("prio.m1_acks", 16'(a1), 16'd6);
        chk("prio.m1_rdata", 16'(o[0].m1_rdata), 16'h005E);
        chk_seq("prio.grants", 8, 8'h77);

        // priority with m0 idle: m1 never forced off
        clear_log();
        for (int j = 0; j < 4; j++) push(0, 1, 1'b1, 16'h6000 + 16'(j), 8'h20 + 8'(j));
        run_idle(0, 50, nr, nw, a0, a1);
        chk("prio_solo.m1_acks", 16'(a1), 16'd4);
        chk_seq("prio_solo.grants", 4, 8'h0F);
        prio_m1[0] = 1'b0;

        // reset during an m0 read
        clear_log();
        mem_rdata[0] = 8'h77;
        push(0, 0, 1'b0, 16'h4444, 8'h00);
        for (k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (o[0].mem_r) break;
        end
        chk("abort.reach_access", 16'(k < 10), 16'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort.mem_r", 16'(o[0].mem_r), 16'd0);
        chk("abort.m0_ack", 16'(o[0].m0_ack), 16'd0);
        chk("abort.busy", 16'(o[0].busy), 16'd0);
        chk("abort.owner", 16'(o[0].owner), 16'd1);
        chk("abort.m0_rdata", 16'(o[0].m0_rdata), 16'h0000);
        chk("abort.state", 16'(u0_state), 16'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        clear_log();
        push(0, 1, 1'b0, 16'h0300, 8'h00);
        run_idle(0, 30, nr, nw, a0, a1);
        chk("abort.m0_acks", 16'(a0), 16'd0);
        chk("abort.m1_acks", 16'(a1), 16'd1);
        chk("abort.m1_rdata", 16'(o[0].m1_rdata), 16'h0077);
        chk_seq("abort.grants", 1, 8'h01);

        // zero wait states, back-to-back m0 reads
        mem_rdata[1] = 8'h11;
        for (int j = 0; j < 3; j++) push(1, 0, 1'b0, 16'h7000 + 16'(j), 8'h00);
        run_idle(1, 40, nr, nw, a0, a1);
        chk("w0.strobes", 16'(nr), 16'd3);
        chk("w0.wr_strobes", 16'(nw), 16'd0);
        chk("w0.m0_acks", 16'(a0), 16'd3);
        chk("w0.m0_rdata", 16'(o[1].m0_rdata), 16'h0011);
        chk("w0.ack_count", 16'(ack_cyc.size()), 16'd3);
        for (int j = 1; j < ack_cyc.size(); j++)
            chk($sformatf("w0.ack_gap[%0d]", j), 16'(ack_cyc[j] - ack_cyc[j-1]), 16'd3);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
